// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and counter widths shared by
// the SPI flash responder. The DUMMY state only exists when
// SPI_FLASH_FAST_READ_EN is defined.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_RDSR      = 8'h05;

    // bit counter spans the 24-bit address phase; byte counter walks the ID
    localparam int BIT_CNT_W  = 5;
    localparam int BYTE_CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_ID,
        ST_STATUS,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI flash pin bundle. master = SoC side driving
// SCK/CS/MOSI/WP/HOLD, slave = flash side driving MISO.
interface spi_flash_responder_if;
    logic spi_sck_i;
    logic spi_cs_ni;
    logic spi_mosi_i;
    logic spi_miso_o;
    logic wp_ni;
    logic hold_ni;

    modport master (output spi_sck_i, spi_cs_ni, spi_mosi_i, wp_ni, hold_ni,
                    input  spi_miso_o);
    modport slave  (input  spi_sck_i, spi_cs_ni, spi_mosi_i, wp_ni, hold_ni,
                    output spi_miso_o);
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-FF synchronizer plus a third stage for one-cycle
// rise/fall pulses. RST_VAL sets the idle level so reset release does not
// fake an edge.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sr;

    // sr[1:0] synchronize, sr[2] holds the previous synchronized level
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) sr <= {3{RST_VAL}};
        else        sr <= {sr[1:0], d_i};
    end

    assign q_o    = sr[1];
    assign rise_o = sr[1] & ~sr[2];
    assign fall_o = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 NOR flash stand-in, oversampled in the
// clk_i domain. Serves READ (0x03), RDID (0x9F), RDSR (0x05) from a
// preloadable byte array. Optional macro SPI_FLASH_FAST_READ_EN adds
// FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          DEPTH    = 4096,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    spi_flash_responder_if.slave     spi,
    input  logic                     load_we_i,
    input  logic [$clog2(DEPTH)-1:0] load_addr_i,
    input  logic [7:0]               load_data_i
);
    localparam int AW = $clog2(DEPTH);
    // only the opcode and the low AW address bits are ever needed
    localparam int SW = (AW > 8) ? AW : 8;

    logic sck_s, sck_rise_raw, sck_fall_raw, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic [2:0] pin_q1, pin_q2;
    logic mosi_s, hold_s, wp_s;

    state_e state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [SW-2:0]         shift_q;
    logic [SW-1:0]         shift_nxt;
    logic [7:0]            opcode;
    logic [AW-1:0]         addr_q;
    logic [2:0]            tx_bit_q;
    logic                  miso_q;
    logic [7:0]            tx_byte, id_byte, rdata_q;
    logic                  in_rx, in_tx;
    logic [7:0]            mem [DEPTH];
`ifdef SPI_FLASH_FAST_READ_EN
    logic                  fast_q;
`endif

    spi_edge_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi.spi_sck_i),
        .q_o(sck_s), .rise_o(sck_rise_raw), .fall_o(sck_fall_raw)
    );
    spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi.spi_cs_ni),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_s, cs_rise};

    // level-only synchronizers for {wp, hold, mosi}
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pin_q1 <= 3'b110;
            pin_q2 <= 3'b110;
        end else begin
            pin_q1 <= {spi.wp_ni, spi.hold_ni, spi.spi_mosi_i};
            pin_q2 <= pin_q1;
        end
    end

    assign mosi_s   = pin_q2[0];
    assign hold_s   = pin_q2[1];
    assign wp_s     = pin_q2[2];
    // HOLD low swallows SCK edges, which freezes everything below
    assign sck_rise = sck_rise_raw & hold_s;
    assign sck_fall = sck_fall_raw & hold_s;

    assign shift_nxt = {shift_q, mosi_s};
    assign opcode    = shift_nxt[7:0];

    assign in_rx = (state_q == ST_CMD) || (state_q == ST_ADDR)
`ifdef SPI_FLASH_FAST_READ_EN
                || (state_q == ST_DUMMY)
`endif
                ;
    assign in_tx = (state_q == ST_DATA) || (state_q == ST_ID) ||
                   (state_q == ST_STATUS) || (state_q == ST_IGNORE);

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next state: advance on the last sampled bit of each receive phase
    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && bit_cnt_q == 5'd7) begin
                        case (opcode)
                            OP_READ:      state_d = ST_ADDR;
                            OP_RDID:      state_d = ST_ID;
                            OP_RDSR:      state_d = ST_STATUS;
`ifdef SPI_FLASH_FAST_READ_EN
                            OP_FAST_READ: state_d = ST_ADDR;
`endif
                            default:      state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise && bit_cnt_q == 5'd23) begin
`ifdef SPI_FLASH_FAST_READ_EN
                        state_d = fast_q ? ST_DUMMY : ST_DATA;
`else
                        state_d = ST_DATA;
`endif
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                ST_DUMMY: if (sck_rise && bit_cnt_q == 5'd7) state_d = ST_DATA;
`endif
                default: ;
            endcase
        end
    end

    // byte presented on MISO in the current response state
    always_comb begin
        id_byte = 8'h00;
        case (byte_cnt_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
        tx_byte = 8'hFF;
        case (state_q)
            ST_DATA:   tx_byte = rdata_q;
            ST_ID:     tx_byte = id_byte;
            ST_STATUS: tx_byte = {7'b0, ~wp_s};
            default:   tx_byte = 8'hFF;
        endcase
    end

    // shift-in on SCK rise, shift-out on SCK fall; CS high clears the lot
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            tx_bit_q   <= '0;
            miso_q     <= 1'b1;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else if (cs_s) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_bit_q   <= '0;
            miso_q     <= 1'b1;
        end else begin
            if (sck_rise && in_rx) begin
                shift_q   <= shift_nxt[SW-2:0];
                bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
                if (state_q == ST_ADDR && bit_cnt_q == 5'd23)
                    addr_q <= shift_nxt[AW-1:0];
`ifdef SPI_FLASH_FAST_READ_EN
                if (state_q == ST_CMD && bit_cnt_q == 5'd7)
                    fast_q <= (opcode == OP_FAST_READ);
`endif
            end
            if (sck_fall && in_tx) begin
                miso_q   <= tx_byte[~tx_bit_q];
                tx_bit_q <= tx_bit_q + 1'b1;
                // bit 0 going out: step to the next byte so the array read
                // settles well before the following fall
                if (tx_bit_q == 3'd7) begin
                    addr_q <= addr_q + 1'b1;
                    if (byte_cnt_q != 2'd3) byte_cnt_q <= byte_cnt_q + 1'b1;
                end
            end
        end
    end

    // byte array: preload write, write-first synchronous read of addr_q
    always_ff @(posedge clk_i) begin
        if (load_we_i) mem[load_addr_i] <= load_data_i;
        rdata_q <= (load_we_i && load_addr_i == addr_q) ? load_data_i : mem[addr_q];
    end

    assign spi.spi_miso_o = miso_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI mode-0 transactions against the
// responder with hand-computed expected bytes. Honors SPI_FLASH_FAST_READ_EN.
module tb_spi_flash_responder;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        load_we_i;
    logic [11:0] load_addr_i;
    logic [7:0]  load_data_i;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  rx;

    spi_flash_responder_if sif();

    spi_flash_responder #(.DEPTH(4096), .JEDEC_ID(24'hEF4016)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .spi(sif),
        .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        load_we_i = 1'b1; load_addr_i = a; load_data_i = d;
        wait_clk(1);
        load_we_i = 1'b0;
    endtask

    // mode 0: set MOSI while SCK low, sample MISO just before SCK rises
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sif.spi_mosi_i = tx[i];
            wait_clk(8);
            r[i] = sif.spi_miso_o;
            sif.spi_sck_i = 1'b1;
            wait_clk(8);
            sif.spi_sck_i = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        xfer_bits(tx, 8, r);
    endtask

    task automatic cs_low();
        sif.spi_cs_ni = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(8);
        sif.spi_cs_ni = 1'b1;
        wait_clk(8);
    endtask

    task automatic send_read_hdr(input logic [7:0] op, input logic [23:0] a);
        xfer(op, rx);
        xfer(a[23:16], rx);
        xfer(a[15:8], rx);
        xfer(a[7:0], rx);
    endtask

    initial begin
        rst_i = 1'b0;
        sif.spi_cs_ni = 1'b1; sif.spi_sck_i = 1'b0; sif.spi_mosi_i = 1'b0;
        sif.wp_ni = 1'b1; sif.hold_ni = 1'b1;
        load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
        wait_clk(4);
        rst_i = 1'b1;
        wait_clk(4);
        check8("reset_miso", {7'b0, sif.spi_miso_o}, 8'h01);

        load(12'h000, 8'hA5); load(12'h001, 8'h5A);
        load(12'h002, 8'hC3); load(12'h003, 8'h3C);
        load(12'hFFF, 8'h77);

        // READ from 0
        cs_low();
        send_read_hdr(8'h03, 24'h000000);
        xfer(8'h00, rx); check8("read_b0", rx, 8'hA5);
        xfer(8'h00, rx); check8("read_b1", rx, 8'h5A);
        xfer(8'h00, rx); check8("read_b2", rx, 8'hC3);
        xfer(8'h00, rx); check8("read_b3", rx, 8'h3C);
        cs_high();

        // RDID
        cs_low();
        xfer(8'h9F, rx);
        xfer(8'h00, rx); check8("rdid_b0", rx, 8'hEF);
        xfer(8'h00, rx); check8("rdid_b1", rx, 8'h40);
        xfer(8'h00, rx); check8("rdid_b2", rx, 8'h16);
        xfer(8'h00, rx); check8("rdid_b3", rx, 8'h00);
        cs_high();

        // READ at DEPTH-1 wraps to 0
        cs_low();
        send_read_hdr(8'h03, 24'h000FFF);
        xfer(8'h00, rx); check8("wrap_last", rx, 8'h77);
        xfer(8'h00, rx); check8("wrap_first", rx, 8'hA5);
        cs_high();

        // RDSR reflects WP pin
        sif.wp_ni = 1'b0;
        cs_low();
        xfer(8'h05, rx);
        xfer(8'h00, rx); check8("rdsr_wp0", rx, 8'h01);
        cs_high();
        sif.wp_ni = 1'b1;
        cs_low();
        xfer(8'h05, rx);
        xfer(8'h00, rx); check8("rdsr_wp1", rx, 8'h00);
        cs_high();

        // unknown opcode keeps MISO high
        cs_low();
        xfer(8'hFF, rx);
        xfer(8'h00, rx); check8("ign_b0", rx, 8'hFF);
        xfer(8'h00, rx); check8("ign_b1", rx, 8'hFF);
        cs_high();

        // abort a READ after 12 address bits, then a clean READ
        cs_low();
        xfer(8'h03, rx);
        xfer(8'h00, rx);
        xfer_bits(8'h00, 4, rx);
        cs_high();
        check8("abort_miso", {7'b0, sif.spi_miso_o}, 8'h01);
        cs_low();
        send_read_hdr(8'h03, 24'h000002);
        xfer(8'h00, rx); check8("after_abort", rx, 8'hC3);
        cs_high();

        // FAST_READ with 8 dummy clocks
        cs_low();
        send_read_hdr(8'h0B, 24'h000001);
        xfer(8'h00, rx);
`ifdef SPI_FLASH_FAST_READ_EN
        xfer(8'h00, rx); check8("fast_b0", rx, 8'h5A);
        xfer(8'h00, rx); check8("fast_b1", rx, 8'hC3);
`else
        xfer(8'h00, rx); check8("fast_b0", rx, 8'hFF);
        xfer(8'h00, rx); check8("fast_b1", rx, 8'hFF);
`endif
        cs_high();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
